// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID register,
// and a one-entry hold buffer that absorbs decode stalls.
module if_fetch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             id_stall,
  input  logic             flush,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pcplus4_d,
  output logic             valid_d
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic             ifid_vld_q, ifid_vld_d;
  logic             accept;

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_vld_d   = ifid_vld_q;
    accept       = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // A grant under flush fetched the old address: drop its data.
        if (imem_gnt) state_d = flush ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            state_d = S_REQ;
          end else if (id_stall) begin
            state_d = S_HOLD;
            buf_d   = imem_rdata;
          end else begin
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_REQ;
        end else if (!id_stall) begin
          accept  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (accept) begin
      ifid_instr_d = (state_q == S_HOLD) ? buf_q : imem_rdata;
      ifid_pc_d    = pc;
      ifid_pc4_d   = pc + WIDTH'(4);
      ifid_vld_d   = 1'b1;
    end else if (flush || !id_stall) begin
      ifid_vld_d   = 1'b0;
    end
  end

  // pc is frozen from request to accept, so it still names this fetch.
  assign pc_en     = accept | flush;
  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc;
  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign pcplus4_d = ifid_pc4_q;
  assign valid_d   = ifid_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      buf_q        <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

endmodule
